// File: rtl/mem_bist.sv
// mem_bist: write/read sweep memory self-test over DEPTH locations starting at BASE_ADDR.
// Modes: 0 constant PATTERN, 1 address-derived data, 2 checkerboard, 3 read-only checksum.
// Reads are pipelined back-to-back; each returned word is checked one cycle after issue.
module mem_bist #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h8000,
    parameter int unsigned           DEPTH      = 32768,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  aborted,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int unsigned OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(DEPTH - 1);

    // Alternating 0101... word (8'h55 at 8 bits), built wide then trimmed for odd widths
    localparam int unsigned CHK_PAIRS = (DATA_WIDTH + 1) / 2;
    localparam logic [2*CHK_PAIRS-1:0] CHK_WIDE = {CHK_PAIRS{2'b01}};
    localparam logic [DATA_WIDTH-1:0] CHECKER = CHK_WIDE[DATA_WIDTH-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              mode_q;
    logic [OFF_W-1:0]        off_q;
    logic                    pend_q;
    logic [OFF_W-1:0]        pend_off_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    mem_we_q;
    logic                    mem_oe_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    aborted_q;
    logic [15:0]             err_count_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [DATA_WIDTH-1:0]   checksum_q;

    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    mism;
    logic [15:0]             err_d;

    function automatic logic [DATA_WIDTH-1:0] data_of(input logic [1:0] m, input logic [OFF_W-1:0] off);
        case (m)
            2'd0:    data_of = PATTERN;
            2'd1:    data_of = DATA_WIDTH'(off);
            2'd2:    data_of = off[0] ? ~CHECKER : CHECKER;
            default: data_of = '0;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [OFF_W-1:0] off);
        return BASE_ADDR + ADDR_WIDTH'(off);
    endfunction

    // Compare the word returning this cycle and form the saturating error count
    always_comb begin
        exp_data = data_of(mode_q, pend_off_q);
        mism     = pend_q && (mode_q != 2'd3) && (mem_rdata != exp_data);
        err_d    = err_count_q;
        if (mism && (err_count_q != 16'hFFFF)) begin
            err_d = err_count_q + 16'd1;
        end
    end

    // Sweep sequencer, read-compare pipeline and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            off_q       <= '0;
            pend_q      <= 1'b0;
            pend_off_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            checksum_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && abort) begin
                // A read still in flight is dropped: it is neither compared nor summed
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                mem_we_q  <= 1'b0;
                mem_oe_q  <= 1'b0;
                pend_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                if (pend_q) begin
                    checksum_q  <= checksum_q + mem_rdata;
                    err_count_q <= err_d;
                    if (mism && (err_count_q == '0)) begin
                        fail_addr_q <= addr_of(pend_off_q);
                    end
                end
                pend_q     <= (state_q == S_READ);
                pend_off_q <= off_q;
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            mode_q      <= mode;
                            off_q       <= '0;
                            busy_q      <= 1'b1;
                            pass_q      <= 1'b0;
                            aborted_q   <= 1'b0;
                            err_count_q <= '0;
                            fail_addr_q <= '0;
                            checksum_q  <= '0;
                            mem_addr_q  <= BASE_ADDR;
                            if (mode == 2'd3) begin
                                state_q  <= S_READ;
                                mem_oe_q <= 1'b1;
                            end else begin
                                state_q     <= S_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= data_of(mode, '0);
                            end
                        end
                    end
                    S_WRITE: begin
                        if (off_q == LAST_OFF) begin
                            state_q     <= S_READ;
                            off_q       <= '0;
                            mem_we_q    <= 1'b0;
                            mem_oe_q    <= 1'b1;
                            mem_addr_q  <= addr_of('0);
                            mem_wdata_q <= '0;
                        end else begin
                            off_q       <= off_q + 1'b1;
                            mem_addr_q  <= addr_of(off_q + 1'b1);
                            mem_wdata_q <= data_of(mode_q, off_q + 1'b1);
                        end
                    end
                    S_READ: begin
                        if (off_q == LAST_OFF) begin
                            state_q  <= S_FLUSH;
                            mem_oe_q <= 1'b0;
                        end else begin
                            off_q      <= off_q + 1'b1;
                            mem_addr_q <= addr_of(off_q + 1'b1);
                        end
                    end
                    S_FLUSH: begin
                        // The final compare lands on this edge, so pass uses the updated count
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;
    assign err_count = err_count_q;
    assign fail_addr = fail_addr_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: two DEPTH=4 instances (base 8000 and base FFFE) with behavioural memories.
// Cycle numbering: cycle k is the k-th clock period after the edge that samples start.
module tb_mem_bist;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_s [2];
    logic [1:0]  mode_s  [2];
    logic        abort_s [2];
    logic [15:0] addr_w  [2];
    logic [7:0]  wdata_w [2];
    logic        we_w    [2];
    logic        oe_w    [2];
    logic [7:0]  rdata_r [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        pass_w  [2];
    logic        ab_w    [2];
    logic [15:0] err_w   [2];
    logic [15:0] fa_w    [2];
    logic [7:0]  cs_w    [2];

    logic        tb_we [2];
    logic [15:0] tb_addr;
    logic [7:0]  tb_data;
    logic        stuck_en   [2];
    logic [15:0] stuck_addr [2];
    logic [7:0]  mem    [2][65536];
    logic [7:0]  shadow [2][65536];

    int vec = 0;
    int errs = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
    } acc_t;

    mem_bist #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(16'h8000), .DEPTH(D), .PATTERN(8'h25)) u_a (
        .clk(clk), .reset(reset), .start(start_s[0]), .mode(mode_s[0]), .abort(abort_s[0]),
        .mem_addr(addr_w[0]), .mem_wdata(wdata_w[0]), .mem_we(we_w[0]), .mem_oe(oe_w[0]),
        .mem_rdata(rdata_r[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .aborted(ab_w[0]), .err_count(err_w[0]), .fail_addr(fa_w[0]), .checksum(cs_w[0]));

    mem_bist #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(16'hFFFE), .DEPTH(D), .PATTERN(8'h25)) u_b (
        .clk(clk), .reset(reset), .start(start_s[1]), .mode(mode_s[1]), .abort(abort_s[1]),
        .mem_addr(addr_w[1]), .mem_wdata(wdata_w[1]), .mem_we(we_w[1]), .mem_oe(oe_w[1]),
        .mem_rdata(rdata_r[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .aborted(ab_w[1]), .err_count(err_w[1]), .fail_addr(fa_w[1]), .checksum(cs_w[1]));

    // Synchronous memories: write on the edge with we high, read data one cycle after oe
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we_w[i]) mem[i][addr_w[i]] <= wdata_w[i];
            else if (tb_we[i]) mem[i][tb_addr] <= tb_data;
            if (oe_w[i]) rdata_r[i] <= (stuck_en[i] && addr_w[i] == stuck_addr[i]) ? 8'h00 : mem[i][addr_w[i]];
        end
    end

    function automatic logic [15:0] base_of(input int i);
        return (i == 0) ? 16'h8000 : 16'hFFFE;
    endfunction

    function automatic logic [7:0] pat(input logic [1:0] m, input int k);
        logic [7:0] kk;
        kk = k[7:0];
        case (m)
            2'd0:    return 8'h25;
            2'd1:    return kk;
            2'd2:    return (k % 2 == 0) ? 8'h55 : 8'hAA;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [31:0] words);
        for (int k = 0; k < D; k++) begin
            tb_we[i] = 1'b1;
            tb_addr  = base_of(i) + 16'(k);
            tb_data  = words[8*k +: 8];
            shadow[i][tb_addr] = tb_data;
            step();
        end
        tb_we[i] = 1'b0;
    endtask

    // Full sweep on instance i, checked against an access list and status derived from the rules
    task automatic run_sweep(input int i, input logic [1:0] m, input bit ab_start);
        acc_t        q[$];
        logic [15:0] base, a, fa;
        logic [7:0]  v, sum;
        int          nerr, c, idx, done_c, ndone, extra, exp_done;
        logic        conflict, busy1;
        base = base_of(i);
        sum  = 8'h00;
        nerr = 0;
        fa   = 16'h0000;
        if (m != 2'd3) begin
            for (int k = 0; k < D; k++) q.push_back({1'b1, base + 16'(k), pat(m, k)});
        end
        for (int k = 0; k < D; k++) begin
            a = base + 16'(k);
            v = (stuck_en[i] && a == stuck_addr[i]) ? 8'h00 : ((m == 2'd3) ? shadow[i][a] : pat(m, k));
            q.push_back({1'b0, a, v});
            sum = sum + v;
            if (m != 2'd3 && v != pat(m, k)) begin
                if (nerr == 0) fa = a;
                nerr++;
            end
        end
        exp_done = (m == 2'd3) ? D + 2 : 2 * D + 2;

        start_s[i] = 1'b1;
        mode_s[i]  = m;
        abort_s[i] = ab_start;
        step();
        start_s[i] = 1'b0;
        abort_s[i] = 1'b0;
        mode_s[i]  = 2'($urandom_range(3, 0));
        c = 1; idx = 0; done_c = 0; ndone = 0; extra = 0; conflict = 1'b0;
        busy1 = busy_w[i];
        while (c <= 2 * D + 8) begin
            if (c == 3) begin
                start_s[i] = 1'b1;
                mode_s[i]  = 2'($urandom_range(3, 0));
            end else begin
                start_s[i] = 1'b0;
            end
            if (we_w[i] && oe_w[i]) conflict = 1'b1;
            if (we_w[i] || oe_w[i]) begin
                if (idx < q.size()) begin
                    chk("access_kind", 32'(we_w[i]), 32'(q[idx].wr));
                    chk("access_addr", 32'(addr_w[i]), 32'(q[idx].a));
                    if (we_w[i]) chk("write_data", 32'(wdata_w[i]), 32'(q[idx].d));
                    idx++;
                end else begin
                    extra++;
                end
            end
            if (done_w[i]) begin
                ndone++;
                if (done_c == 0) done_c = c;
            end
            step();
            c++;
        end
        start_s[i] = 1'b0;
        chk("busy_cycle1", 32'(busy1), 32'd1);
        chk("we_oe_exclusive", 32'(conflict), 32'd0);
        chk("access_count", 32'(idx), 32'(q.size()));
        chk("extra_access", 32'(extra), 32'd0);
        chk("done_cycle", 32'(done_c), 32'(exp_done));
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("busy_end", 32'(busy_w[i]), 32'd0);
        chk("pass", 32'(pass_w[i]), 32'(nerr == 0));
        chk("aborted_clear", 32'(ab_w[i]), 32'd0);
        chk("err_count", 32'(err_w[i]), 32'(nerr));
        chk("fail_addr", 32'(fa_w[i]), 32'(fa));
        chk("checksum", 32'(cs_w[i]), 32'(sum));
        if (m != 2'd3) begin
            for (int k = 0; k < D; k++) shadow[i][base + 16'(k)] = pat(m, k);
        end
    endtask

    initial begin
        int dn;
        reset   = 1'b0;
        tb_addr = 16'h0000;
        tb_data = 8'h00;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; mode_s[i] = 2'd0; abort_s[i] = 1'b0;
            tb_we[i] = 1'b0; stuck_en[i] = 1'b0; stuck_addr[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", 32'(busy_w[i]), 32'd0);
            chk("reset_we_oe", 32'({we_w[i], oe_w[i]}), 32'd0);
            chk("reset_addr", 32'(addr_w[i]), 32'd0);
            chk("reset_status", 32'({done_w[i], pass_w[i], ab_w[i], err_w[i]}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Constant pattern, ideal memory, start on first edge after reset release
        run_sweep(0, 2'd0, 1'b0);
        chk("const_checksum_94", 32'(cs_w[0]), 32'h94);

        // Address pattern with 8002 reading back 00
        stuck_en[0] = 1'b1;
        stuck_addr[0] = 16'h8002;
        run_sweep(0, 2'd1, 1'b0);
        chk("stuck_err_1", 32'(err_w[0]), 32'd1);
        chk("stuck_fail_8002", 32'(fa_w[0]), 32'h8002);
        stuck_en[0] = 1'b0;

        // Checkerboard across the address wrap
        run_sweep(1, 2'd2, 1'b0);

        // Read-only checksum over preloaded 01..04
        preload(0, 32'h04030201);
        run_sweep(0, 2'd3, 1'b0);
        chk("ro_checksum_0a", 32'(cs_w[0]), 32'h0A);

        // Abort while idle has no effect
        abort_s[0] = 1'b1;
        step();
        abort_s[0] = 1'b0;
        chk("idle_abort_aborted", 32'(ab_w[0]), 32'd0);
        chk("idle_abort_pass", 32'(pass_w[0]), 32'd1);
        chk("idle_abort_busy", 32'(busy_w[0]), 32'd0);

        // Start and abort together in idle: start wins
        run_sweep(0, 2'd2, 1'b1);

        // Abort in the second read cycle, with an ignored start earlier in the sweep
        start_s[0] = 1'b1;
        mode_s[0]  = 2'd0;
        step();
        start_s[0] = 1'b0;
        for (int c = 1; c <= D + 1; c++) begin
            start_s[0] = (c == 2);
            mode_s[0]  = 2'd3;
            step();
        end
        start_s[0] = 1'b0;
        chk("abort_pre_oe", 32'(oe_w[0]), 32'd1);
        chk("abort_pre_addr", 32'(addr_w[0]), 32'h8001);
        abort_s[0] = 1'b1;
        step();
        abort_s[0] = 1'b0;
        chk("abort_aborted", 32'(ab_w[0]), 32'd1);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_we_oe", 32'({we_w[0], oe_w[0]}), 32'd0);
        chk("abort_pass", 32'(pass_w[0]), 32'd0);
        dn = 0;
        repeat (3 * D) begin
            if (done_w[0] || we_w[0] || oe_w[0]) dn = 1;
            step();
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        chk("abort_hold", 32'(ab_w[0]), 32'd1);
        for (int k = 0; k < D; k++) shadow[0][16'h8000 + 16'(k)] = 8'h25;

        // Reset in mid-write forces all outputs low at once
        start_s[0] = 1'b1;
        mode_s[0]  = 2'd1;
        step();
        start_s[0] = 1'b0;
        step();
        chk("rst_pre_we", 32'(we_w[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_addr_wdata", 32'({addr_w[0], wdata_w[0]}), 32'd0);
        chk("rst_we_oe", 32'({we_w[0], oe_w[0]}), 32'd0);
        chk("rst_flags", 32'({busy_w[0], done_w[0], pass_w[0], ab_w[0]}), 32'd0);
        chk("rst_err_fail", 32'({err_w[0], fa_w[0]}), 32'd0);
        chk("rst_checksum", 32'(cs_w[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_sweep(0, 2'd1, 1'b0);

        // Randomised sweeps: random instance, mode, contents, read fault and start/abort overlap
        repeat (10) begin
            int ri;
            ri = int'($urandom_range(1, 0));
            preload(ri, $urandom);
            stuck_en[ri]   = ($urandom_range(1, 0) == 1);
            stuck_addr[ri] = base_of(ri) + 16'($urandom_range(5, 0));
            run_sweep(ri, 2'($urandom_range(3, 0)), ($urandom_range(1, 0) == 1));
            stuck_en[ri] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
